// File: rtl/unidade_controle.sv
// unidade_controle: multicycle control FSM for the RV64 datapath.
// Drives the IR/PC/register/memory write enables and the Mux1/Mux2 selects
// from the registered state and the latched opcode. The PC next-value choice
// stays in Mux3; this block only says when the PC loads.
//
// state  | meaning
// FETCH  | IR loads while run=1, opcode latched into op_q
// DECODE | register read, opcode legality check
// EXEC   | ALU operation; BEQ retires here
// MEM    | data memory access; SD retires here
// WB     | register write-back; R/I-ALU/LD retire here
// TRAP   | illegal opcode seen, parked until reset
module unidade_controle #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic [6:0]           opcode,
  output logic                 weIR,
  output logic                 wePC,
  output logic                 weReg,
  output logic                 weMem,
  output logic                 sinalMux1,
  output logic                 sinalMux2,
  output logic [2:0]           estado,
  output logic                 erro,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t               state_q, state_d;
  logic [6:0]           op_q, op_d;
  logic                 erro_q, erro_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic is_ld, is_sd, is_beq, is_legal, uses_imm;
  logic ir_c, pc_c, reg_c, mem_c, mux1_c, mux2_c;

  // Opcode class flags derived from the latched opcode only.
  always_comb begin
    is_ld    = (op_q == OP_LD);
    is_sd    = (op_q == OP_SD);
    is_beq   = (op_q == OP_BEQ);
    is_legal = (op_q == OP_R) || (op_q == OP_I) || is_ld || is_sd || is_beq;
    uses_imm = (op_q == OP_I) || is_ld || is_sd;
  end

  // Moore decode of enables and selects; run only qualifies the IR load in FETCH.
  always_comb begin
    ir_c   = 1'b0;
    pc_c   = 1'b0;
    reg_c  = 1'b0;
    mem_c  = 1'b0;
    mux1_c = 1'b0;
    mux2_c = 1'b1;
    case (state_q)
      FETCH: ir_c = run;
      EXEC: begin
        mux1_c = uses_imm;
        pc_c   = is_beq;
      end
      MEM: begin
        mux1_c = 1'b1;
        mem_c  = is_sd;
        pc_c   = is_sd;
      end
      WB: begin
        mux1_c = uses_imm;
        reg_c  = 1'b1;
        pc_c   = 1'b1;
        mux2_c = ~is_ld;
      end
      default: ;
    endcase
  end

  // Reset gates the outputs directly so an in-flight write or PC load is cut
  // off the moment reset rises, not at the next edge.
  always_comb begin
    weIR      = ir_c   & ~reset;
    wePC      = pc_c   & ~reset;
    weReg     = reg_c  & ~reset;
    weMem     = mem_c  & ~reset;
    sinalMux1 = mux1_c & ~reset;
    sinalMux2 = mux2_c & ~reset;
    estado    = state_q;
    erro      = erro_q;
    instr_cnt = cnt_q;
  end

  // Next-state, opcode latch, sticky error and retired-instruction count.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    erro_d  = erro_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH: begin
        if (run) begin
          op_d    = opcode;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_legal) begin
          state_d = EXEC;
        end else begin
          state_d = TRAP;
          erro_d  = 1'b1;
        end
      end
      EXEC: begin
        if (is_beq)              state_d = FETCH;
        else if (is_ld || is_sd) state_d = MEM;
        else                     state_d = WB;
      end
      MEM:     state_d = is_sd ? FETCH : WB;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    if (pc_c) cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  // State register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= 7'd0;
      erro_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      erro_q  <= erro_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
